// File: rtl/uart_text_terminal.sv
// Four-row by 16-column text terminal buffer fed by UART bytes.
// Handles cursor, line wrap, CR/LF/BS/FF and scroll-up, and serves reads to the text engine.
module uart_text_terminal #(
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byteReady,
  input  logic [7:0] dataIn,
  input  logic [5:0] charAddress,
  output logic [7:0] charOutput,
  output logic [1:0] cursorRow,
  output logic [3:0] cursorCol,
  output logic       busy
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    EXEC,
    SCROLL
  } stateType;

  stateType   state, nextState;
  logic [5:0] idx, nextIdx;
  logic [1:0] row, nextRow;
  logic [3:0] col, nextCol;
  logic       pending;
  logic [7:0] pendingByte;
  logic       byteReadyPrev;
  logic       byteEdge;

  logic [7:0] mem [64];
  logic       memWe;
  logic [5:0] memAddr;
  logic [7:0] memData;

  assign byteEdge  = byteReady && !byteReadyPrev;
  assign cursorRow = row;
  assign cursorCol = col;
  assign busy      = (state == CLEAR) || (state == SCROLL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= 6'd0;
      row   <= 2'd0;
      col   <= 4'd0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
      row   <= nextRow;
      col   <= nextCol;
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    nextRow   = row;
    nextCol   = col;
    memWe     = 1'b0;
    memAddr   = idx;
    memData   = BLANK;
    unique case (state)
      CLEAR: begin
        memWe   = 1'b1;
        nextIdx = idx + 6'd1;
        if (idx == 6'd63) nextState = IDLE;
      end
      IDLE: begin
        if (pending) nextState = EXEC;
      end
      EXEC: begin
        nextState = IDLE;
        nextIdx   = 6'd0;
        if (pendingByte >= 8'h20 && pendingByte <= 8'h7E) begin
          memWe   = 1'b1;
          memAddr = {row, col};
          memData = pendingByte;
          if (col == 4'd15) begin
            nextCol = 4'd0;
            if (row == 2'd3) nextState = SCROLL;
            else             nextRow   = row + 2'd1;
          end else begin
            nextCol = col + 4'd1;
          end
        end else begin
          case (pendingByte)
            8'h0D: nextCol = 4'd0;
            8'h0A: begin
              nextCol = 4'd0;
              if (row == 2'd3) nextState = SCROLL;
              else             nextRow   = row + 2'd1;
            end
            8'h08: begin
              if (col != 4'd0) begin
                nextCol = col - 4'd1;
                memWe   = 1'b1;
                memAddr = {row, col - 4'd1};
                memData = BLANK;
              end
            end
            8'h0C: begin
              nextRow   = 2'd0;
              nextCol   = 4'd0;
              nextState = CLEAR;
            end
            default: ;
          endcase
        end
      end
      SCROLL: begin
        // Each row moves up one; the bottom row is refilled with blanks.
        memWe   = 1'b1;
        memData = (idx < 6'd48) ? mem[idx + 6'd16] : BLANK;
        nextIdx = idx + 6'd1;
        if (idx == 6'd63) nextState = IDLE;
      end
      default: nextState = CLEAR;
    endcase
  end

  // One-deep byte capture; edges arriving while a byte is still waiting are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteReadyPrev <= 1'b1;
      pending       <= 1'b0;
      pendingByte   <= 8'h00;
    end else begin
      byteReadyPrev <= byteReady;
      if (state == EXEC) begin
        pending <= 1'b0;
      end else if (byteEdge && !pending) begin
        pending     <= 1'b1;
        pendingByte <= dataIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               charOutput <= BLANK;
    else if (state == CLEAR)  charOutput <= BLANK;
    else                      charOutput <= mem[charAddress];
  end

endmodule

// File: tb/tb_uart_text_terminal.sv
// Bench for uart_text_terminal: directed table, wrap/scroll sequences, random bytes
// against a screen-level reference model, and a reset that lands mid-scroll.
module tb_uart_text_terminal;

  localparam logic [7:0] BLANK = 8'h20;

  logic       clk;
  logic       rst_n;
  logic       byteReady;
  logic [7:0] dataIn;
  logic [5:0] charAddress;
  logic [7:0] charOutput;
  logic [1:0] cursorRow;
  logic [3:0] cursorCol;
  logic       busy;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] modelMem [64];
  int         mRow;
  int         mCol;

  typedef struct {
    logic [7:0] data;
    int         hold;
    int         expRow;
    int         expCol;
    int         probe;
    logic [7:0] expChar;
    int         expBusy;
  } vecT;

  vecT vecs [14];

  uart_text_terminal #(.BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byteReady  (byteReady),
    .dataIn     (dataIn),
    .charAddress(charAddress),
    .charOutput (charOutput),
    .cursorRow  (cursorRow),
    .cursorCol  (cursorCol),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 64; i++) modelMem[i] = BLANK;
    mRow = 0;
    mCol = 0;
  endtask

  task automatic modelScroll();
    for (int i = 0; i < 48; i++) modelMem[i] = modelMem[i + 16];
    for (int i = 48; i < 64; i++) modelMem[i] = BLANK;
  endtask

  // Screen behaviour expressed as cursor arithmetic on a flat 64-cell array.
  task automatic modelByte(input logic [7:0] b, output int expBusy);
    expBusy = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      modelMem[mRow * 16 + mCol] = b;
      mCol++;
      if (mCol == 16) begin
        mCol = 0;
        if (mRow == 3) begin
          modelScroll();
          expBusy = 64;
        end else mRow++;
      end
    end else if (b == 8'h0D) begin
      mCol = 0;
    end else if (b == 8'h0A) begin
      mCol = 0;
      if (mRow == 3) begin
        modelScroll();
        expBusy = 64;
      end else mRow++;
    end else if (b == 8'h08) begin
      if (mCol > 0) begin
        mCol--;
        modelMem[mRow * 16 + mCol] = BLANK;
      end
    end else if (b == 8'h0C) begin
      modelClear();
      expBusy = 64;
    end
  endtask

  task automatic readCell(input int addr, output int value);
    @(negedge clk);
    charAddress = 6'(addr);
    @(negedge clk);
    value = int'(charOutput);
  endtask

  task automatic checkScreen(input string tag);
    int v;
    for (int i = 0; i < 64; i++) begin
      readCell(i, v);
      checkOutput($sformatf("%s cell %0d", tag, i), v, int'(modelMem[i]));
    end
  endtask

  // Sends one byte as a byteReady level held for 'hold' cycles and waits until the terminal is idle.
  task automatic applyStimulus(input logic [7:0] b, input int hold, input string tag, output int busyCycles);
    int expBusy;
    busyCycles = 0;
    @(negedge clk);
    dataIn    = b;
    byteReady = 1'b1;
    for (int k = 0; k < hold + 150; k++) begin
      @(negedge clk);
      if (k == hold - 1) byteReady = 1'b0;
      if (busy) busyCycles++;
      if (k >= hold && k >= 4 && !busy) break;
    end
    byteReady = 1'b0;
    modelByte(b, expBusy);
    checkOutput({tag, " settled"}, int'(busy), 0);
    checkOutput({tag, " busy cycles"}, busyCycles, expBusy);
    checkOutput({tag, " cursor"}, int'({cursorRow, cursorCol}), mRow * 16 + mCol);
  endtask

  task automatic waitClearDone(input string tag);
    int cnt;
    int allBlank;
    cnt = 0;
    allBlank = 1;
    while (busy && cnt < 200) begin
      if (charOutput !== BLANK) allBlank = 0;
      cnt++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, cnt, 64);
    checkOutput({tag, " blank output during clear"}, allBlank, 1);
    modelClear();
  endtask

  initial begin
    int bc;
    int v;
    int k;
    int r;
    logic [7:0] b;

    rst_n       = 1'b0;
    byteReady   = 1'b0;
    dataIn      = 8'h00;
    charAddress = 6'd0;

    vecs[0]  = '{8'h41, 100, 0, 1,  0, 8'h41, 0};
    vecs[1]  = '{8'h0C,   2, 0, 0,  0, 8'h20, 64};
    vecs[2]  = '{8'h41,   3, 0, 1,  0, 8'h41, 0};
    vecs[3]  = '{8'h42,   1, 0, 2,  1, 8'h42, 0};
    vecs[4]  = '{8'h08,   1, 0, 1,  1, 8'h20, 0};
    vecs[5]  = '{8'h08,   2, 0, 0,  0, 8'h20, 0};
    vecs[6]  = '{8'h08,   1, 0, 0,  0, 8'h20, 0};
    vecs[7]  = '{8'h7F,   1, 0, 0,  1, 8'h20, 0};
    vecs[8]  = '{8'h43,   1, 0, 1,  0, 8'h43, 0};
    vecs[9]  = '{8'h0D,   1, 0, 0,  0, 8'h43, 0};
    vecs[10] = '{8'h0A,   1, 1, 0,  0, 8'h43, 0};
    vecs[11] = '{8'h44,   1, 1, 1, 16, 8'h44, 0};
    vecs[12] = '{8'h00,   1, 1, 1, 16, 8'h44, 0};
    vecs[13] = '{8'h0D,   1, 1, 0, 17, 8'h20, 0};

    repeat (3) @(negedge clk);
    checkOutput("in reset busy", int'(busy), 1);
    checkOutput("in reset charOutput", int'(charOutput), 8'h20);
    checkOutput("in reset cursor", int'({cursorRow, cursorCol}), 0);
    rst_n = 1'b1;
    waitClearDone("post-reset");
    checkOutput("post-reset cursor", int'({cursorRow, cursorCol}), 0);
    checkScreen("post-reset");

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].data, vecs[i].hold, $sformatf("vec%0d", i), bc);
      checkOutput($sformatf("vec%0d table busy", i), bc, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d table cursor", i), int'({cursorRow, cursorCol}),
                  vecs[i].expRow * 16 + vecs[i].expCol);
      readCell(vecs[i].probe, v);
      checkOutput($sformatf("vec%0d probe", i), v, int'(vecs[i].expChar));
    end
    checkScreen("table");

    applyStimulus(8'h0C, 2, "wrap ff", bc);
    for (int i = 0; i < 17; i++) applyStimulus(8'h78, 2, $sformatf("wrap x%0d", i), bc);
    checkOutput("wrap cursor (1,1)", int'({cursorRow, cursorCol}), 17);
    readCell(15, v);
    checkOutput("wrap cell 15", v, 8'h78);
    readCell(16, v);
    checkOutput("wrap cell 16", v, 8'h78);
    readCell(17, v);
    checkOutput("wrap cell 17", v, 8'h20);
    checkScreen("wrap");

    applyStimulus(8'h0C, 1, "fill ff", bc);
    for (int i = 0; i < 64; i++) applyStimulus(8'(8'h30 + i / 16), 1, $sformatf("fill %0d", i), bc);
    checkOutput("fill auto-scroll busy", bc, 64);
    checkOutput("fill cursor (3,0)", int'({cursorRow, cursorCol}), 48);
    readCell(0, v);
    checkOutput("fill cell 0", v, 8'h31);
    readCell(32, v);
    checkOutput("fill cell 32", v, 8'h33);
    readCell(48, v);
    checkOutput("fill cell 48", v, 8'h20);
    checkScreen("fill");
    applyStimulus(8'h0A, 1, "lf scroll", bc);
    checkOutput("lf scroll busy", bc, 64);
    checkOutput("lf cursor (3,0)", int'({cursorRow, cursorCol}), 48);
    readCell(0, v);
    checkOutput("lf cell 0", v, 8'h32);
    readCell(16, v);
    checkOutput("lf cell 16", v, 8'h33);
    readCell(32, v);
    checkOutput("lf cell 32", v, 8'h20);
    checkScreen("lf");

    applyStimulus(8'h0C, 1, "rand ff", bc);
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0A;
      else if (r < 83) b = 8'h0D;
      else if (r < 91) b = 8'h08;
      else if (r < 93) b = 8'h0C;
      else if (r < 96) b = 8'($urandom_range(0, 7));
      else             b = 8'($urandom_range(127, 255));
      applyStimulus(b, int'($urandom_range(1, 4)), $sformatf("rand%0d(0x%0h)", i, b), bc);
      if (i % 40 == 39) checkScreen($sformatf("rand%0d", i));
    end

    applyStimulus(8'h0C, 1, "abort ff", bc);
    for (int i = 0; i < 3; i++) applyStimulus(8'h0A, 1, $sformatf("abort lf%0d", i), bc);
    @(negedge clk);
    dataIn    = 8'h0A;
    byteReady = 1'b1;
    @(negedge clk);
    byteReady = 1'b0;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort scroll started", int'(busy), 1);
    dataIn    = 8'h5A;
    byteReady = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort still scrolling", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort async cursor", int'({cursorRow, cursorCol}), 0);
    checkOutput("abort async busy", int'(busy), 1);
    @(negedge clk);
    checkOutput("abort charOutput in reset", int'(charOutput), 8'h20);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitClearDone("abort clear");
    repeat (10) @(negedge clk);
    checkOutput("abort pending discarded cursor", int'({cursorRow, cursorCol}), 0);
    checkOutput("abort idle", int'(busy), 0);
    checkScreen("abort");
    byteReady = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
